// File: rtl/serial_deserializer_if.sv
// Serial link receive bundle: serial line, frame strobe, parallel word handshake and status flags.
// The master drives the serial side and the acknowledge; the slave returns the word and the flags.
interface serial_deserializer_if #(
  parameter int WIDTH = 12
);
  logic             serial_in;
  logic             send;
  logic             ack;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             frame_err;
  logic             overrun;
  logic             parity_err;

  modport master (
    output serial_in, send, ack,
    input  data_out, data_valid, frame_err, overrun, parity_err
  );

  modport slave (
    input  serial_in, send, ack,
    output data_out, data_valid, frame_err, overrun, parity_err
  );
endinterface

// File: rtl/serial_deserializer.sv
// MSB-first serial-to-parallel receiver with valid/ack handshake, truncation and overrun detection.
// Optional trailing even-parity bit checking is enabled by defining PARITY_CHECK_EN.
module serial_deserializer #(
  parameter int WIDTH = 12,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic                 CLK,
  input  logic                 rst,
  serial_deserializer_if.slave bus
);

`ifdef PARITY_CHECK_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FLEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_LOW
  } state_e;

  state_e            state_q;
  logic [FLEN-1:0]   shift_q;
  logic [FLEN-1:0]   shift_d;
  logic [CNT_W-1:0]  count_q;
  logic [WIDTH-1:0]  data_q;
  logic              valid_q;
  logic              ferr_q;
  logic              ovr_q;
`ifdef PARITY_CHECK_EN
  logic              perr_q;
`endif

  assign shift_d = {shift_q[FLEN-2:0], bus.serial_in};

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      ferr_q <= 1'b0;
      // Completion below overrides this clear, so ack on the completion cycle keeps valid high.
      if (bus.ack && valid_q) valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.send) begin
            shift_q <= shift_d;
            count_q <= CNT_W'(1);
            state_q <= SHIFT;
          end
        end

        SHIFT: begin
          if (!bus.send) begin
            ferr_q  <= 1'b1;
            count_q <= '0;
            state_q <= IDLE;
          end else begin
            shift_q <= shift_d;
            count_q <= count_q + CNT_W'(1);
            if (count_q == LAST) begin
              data_q  <= shift_d[FLEN-1 -: WIDTH];
              valid_q <= 1'b1;
              if (valid_q && !bus.ack) ovr_q <= 1'b1;
`ifdef PARITY_CHECK_EN
              perr_q  <= ^shift_d;
`endif
              state_q <= WAIT_LOW;
            end
          end
        end

        WAIT_LOW: begin
          if (!bus.send) begin
            count_q <= '0;
            state_q <= IDLE;
          end
        end

        default: begin
          count_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
`ifdef PARITY_CHECK_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed self-checking bench for serial_deserializer; parity cases follow PARITY_CHECK_EN.
module tb_serial_deserializer;

`ifdef PARITY_CHECK_EN
  localparam int FLEN = 13;
  localparam logic PAR_EN = 1'b1;
`else
  localparam int FLEN = 12;
  localparam logic PAR_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  serial_deserializer_if #(.WIDTH(12)) bus ();

  serial_deserializer #(.WIDTH(12)) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shifts one whole frame (word, then parity bit if enabled); send is left high afterwards.
  task automatic frame(input logic [11:0] w, input logic p, input logic ack_last);
    logic [12:0] full;
    logic [FLEN-1:0] f;
    full = {w, p};
    f = full[12 -: FLEN];
    for (int i = FLEN - 1; i >= 0; i--) begin
      bus.send      = 1'b1;
      bus.serial_in = f[i];
      if (i == 0) bus.ack = ack_last;
      tick();
    end
    bus.ack = 1'b0;
  endtask

  task automatic gap(input int n);
    bus.send      = 1'b0;
    bus.serial_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bus.serial_in = 1'b1;
    bus.send      = 1'b1;
    bus.ack       = 1'b0;

    // Reset with send high: nothing captured
    rst = 1'b1;
    tick();
    tick();
    check("rst_data_out", 32'(bus.data_out), 32'h000);
    check("rst_valid", 32'(bus.data_valid), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_parity_err", 32'(bus.parity_err), 32'd0);
    rst = 1'b0;
    gap(2);
    check("idle_valid", 32'(bus.data_valid), 32'd0);

    // Nominal frame, send held one extra cycle
    frame(12'hDB6, 1'b0, 1'b0);
    check("nom_valid", 32'(bus.data_valid), 32'd1);
    check("nom_data", 32'(bus.data_out), 32'hDB6);
    check("nom_parity", 32'(bus.parity_err), 32'd0);
    bus.send = 1'b1;
    bus.serial_in = 1'b0;
    tick();
    check("hold_data", 32'(bus.data_out), 32'hDB6);
    check("hold_ferr", 32'(bus.frame_err), 32'd0);
    bus.send = 1'b0;
    bus.ack  = 1'b1;
    tick();
    bus.ack  = 1'b0;
    check("ack_valid", 32'(bus.data_valid), 32'd0);
    check("ack_ferr", 32'(bus.frame_err), 32'd0);
    gap(1);

    // Unacknowledged word overwritten -> sticky overrun
    frame(12'hDB6, 1'b0, 1'b0);
    gap(2);
    check("pre_ovr", 32'(bus.overrun), 32'd0);
    frame(12'h911, 1'b1, 1'b0);
    check("ovr_data", 32'(bus.data_out), 32'h911);
    check("ovr_valid", 32'(bus.data_valid), 32'd1);
    check("ovr_flag", 32'(bus.overrun), 32'd1);
    check("ovr_parity", 32'(bus.parity_err), 32'(PAR_EN));
    bus.ack = 1'b1;
    gap(1);
    bus.ack = 1'b0;
    gap(2);
    check("ovr_sticky", 32'(bus.overrun), 32'd1);
    check("ovr_ack_valid", 32'(bus.data_valid), 32'd0);

    // Same sequence with ack on the completion cycle -> no overrun
    rst = 1'b1;
    gap(1);
    rst = 1'b0;
    check("rst2_overrun", 32'(bus.overrun), 32'd0);
    frame(12'hDB6, 1'b0, 1'b0);
    gap(2);
    frame(12'h911, 1'b1, 1'b1);
    check("ackc_data", 32'(bus.data_out), 32'h911);
    check("ackc_valid", 32'(bus.data_valid), 32'd1);
    check("ackc_overrun", 32'(bus.overrun), 32'd0);
    bus.ack = 1'b1;
    gap(1);
    bus.ack = 1'b0;
    gap(1);

    // Truncated frame: 7 bits then send drops
    for (int i = 0; i < 7; i++) begin
      bus.send = 1'b1;
      bus.serial_in = i[0];
      tick();
    end
    check("trunc_ferr_pre", 32'(bus.frame_err), 32'd0);
    bus.send = 1'b0;
    tick();
    check("trunc_ferr", 32'(bus.frame_err), 32'd1);
    check("trunc_data", 32'(bus.data_out), 32'h911);
    check("trunc_valid", 32'(bus.data_valid), 32'd0);
    frame(12'hA5C, 1'b0, 1'b0);
    check("a5c_data", 32'(bus.data_out), 32'hA5C);
    check("a5c_valid", 32'(bus.data_valid), 32'd1);
    check("a5c_ferr", 32'(bus.frame_err), 32'd0);
    bus.ack = 1'b1;
    gap(1);
    bus.ack = 1'b0;
    gap(1);

    // Reset after 5 bits aborts silently
    for (int i = 0; i < 5; i++) begin
      bus.send = 1'b1;
      bus.serial_in = 1'b1;
      tick();
    end
    rst = 1'b1;
    bus.send = 1'b0;
    tick();
    check("mrst_ferr", 32'(bus.frame_err), 32'd0);
    check("mrst_valid", 32'(bus.data_valid), 32'd0);
    rst = 1'b0;
    tick();
    check("mrst_ferr2", 32'(bus.frame_err), 32'd0);
    frame(12'h3F0, 1'b0, 1'b0);
    check("3f0_data", 32'(bus.data_out), 32'h3F0);
    check("3f0_valid", 32'(bus.data_valid), 32'd1);
    check("3f0_parity", 32'(bus.parity_err), 32'd0);
    gap(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
